// File: rtl/ex_mem_branch_reg_if.sv
// EX/MEM boundary bundle: execute-stage results in, memory-stage
// fields, branch redirect and taken count out.
interface ex_mem_branch_reg_if;
  logic        Stall;
  logic        ValidIn;
  logic [31:0] AR;
  logic        Zero;
  logic [31:0] RtData;
  logic [4:0]  WriteRegIn;
  logic        RegWriteIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic        MemToRegIn;
  logic        BranchIn;
  logic        JumpIn;
  logic [1:0]  MemSizeIn;
  logic [31:0] BranchTargetIn;
  logic [31:0] JumpTargetIn;

  logic [31:0] AR_M;
  logic [31:0] WriteData_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic        MemToReg_M;
  logic [1:0]  MemSize_M;
  logic        PCSrc;
  logic [31:0] PCTarget_M;
  logic        Flush;
  logic [31:0] TakenCount;

  modport master (
    output Stall, ValidIn, AR, Zero, RtData,
    output WriteRegIn, RegWriteIn, MemReadIn,
    output MemWriteIn, MemToRegIn, BranchIn,
    output JumpIn, MemSizeIn,
    output BranchTargetIn, JumpTargetIn,
    input  AR_M, WriteData_M, WriteReg_M,
    input  RegWrite_M, MemRead_M, MemWrite_M,
    input  MemToReg_M, MemSize_M, PCSrc,
    input  PCTarget_M, Flush, TakenCount
  );

  modport slave (
    input  Stall, ValidIn, AR, Zero, RtData,
    input  WriteRegIn, RegWriteIn, MemReadIn,
    input  MemWriteIn, MemToRegIn, BranchIn,
    input  JumpIn, MemSizeIn,
    input  BranchTargetIn, JumpTargetIn,
    output AR_M, WriteData_M, WriteReg_M,
    output RegWrite_M, MemRead_M, MemWrite_M,
    output MemToReg_M, MemSize_M, PCSrc,
    output PCTarget_M, Flush, TakenCount
  );
endinterface

// File: rtl/ex_mem_branch_reg.sv
// EX/MEM pipeline register with memory-stage branch/jump resolution,
// redirect/flush generation and a saturating taken-transfer counter.
module ex_mem_branch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic Clk,
  input logic Rst,
  ex_mem_branch_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        zero;
    logic        br;
    logic        jmp;
    logic        regw;
    logic        memr;
    logic        memw;
    logic        m2r;
    logic [1:0]  size;
    logic [4:0]  wr;
    logic [31:0] ar;
    logic [31:0] wd;
    logic [31:0] brtgt;
    logic [31:0] jtgt;
  } st_t;

  st_t         st_q, st_d, bub;
  logic [31:0] cnt_q, cnt_d;
  logic        taken;
  logic        v;

  assign taken = st_q.valid
               & ((st_q.br & st_q.zero) | st_q.jmp);
  assign v = bus.ValidIn;

  always_comb begin
    bub       = '0;
    bub.brtgt = RESET_PC;
    bub.jtgt  = RESET_PC;
  end

  // A taken transfer squashes the EX instruction even under Stall
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (taken) begin
      st_d = bub;
      if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end else if (!bus.Stall) begin
      st_d.valid = v;
      st_d.zero  = bus.Zero;
      st_d.br    = bus.BranchIn & v;
      st_d.jmp   = bus.JumpIn & v;
      st_d.regw  = bus.RegWriteIn & v;
      st_d.memr  = bus.MemReadIn & v;
      st_d.memw  = bus.MemWriteIn & v;
      st_d.m2r   = bus.MemToRegIn & v;
      st_d.size  = bus.MemSizeIn;
      st_d.wr    = bus.WriteRegIn;
      st_d.ar    = bus.AR;
      st_d.wd    = bus.RtData;
      st_d.brtgt = bus.BranchTargetIn;
      st_d.jtgt  = bus.JumpTargetIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      st_q  <= bub;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.AR_M        = st_q.ar;
  assign bus.WriteData_M = st_q.wd;
  assign bus.WriteReg_M  = st_q.wr;
  assign bus.RegWrite_M  = st_q.regw;
  assign bus.MemRead_M   = st_q.memr;
  assign bus.MemWrite_M  = st_q.memw;
  assign bus.MemToReg_M  = st_q.m2r;
  assign bus.MemSize_M   = st_q.size;
  assign bus.PCSrc       = taken;
  assign bus.Flush       = taken;
  assign bus.TakenCount  = cnt_q;
  assign bus.PCTarget_M  = !taken    ? RESET_PC
                         : st_q.jmp ? st_q.jtgt
                         :            st_q.brtgt;

endmodule

// File: tb/tb_ex_mem_branch_reg.sv
// Scoreboard bench for ex_mem_branch_reg: directed EX vectors push
// expected _M outputs; a negedge monitor pops and compares.
module tb_ex_mem_branch_reg;

  localparam logic [31:0] RP = 32'h0000_1000;

  logic Clk;
  logic Rst;
  int   cyc;
  int   errs;
  int   chks;

  ex_mem_branch_reg_if bus ();

  ex_mem_branch_reg #(.RESET_PC(RP)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        st;
    logic        v;
    logic [31:0] ar;
    logic        z;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [3:0]  ctl;
    logic        br;
    logic        jp;
    logic [1:0]  sz;
    logic [31:0] bt;
    logic [31:0] jt;
  } in_t;

  typedef struct packed {
    logic [31:0] ar;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [3:0]  ctl;
    logic [1:0]  sz;
    logic        pcsrc;
    logic        flush;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t e;
  } ent_t;

  ent_t  sb[$];
  string nq[$];

  // ctl order: RegWrite, MemRead, MemWrite, MemToReg
  function automatic in_t mi(
    logic st, logic v, logic [31:0] ar, logic z,
    logic [31:0] wd, logic [4:0] wr, logic [3:0] ctl,
    logic br, logic jp, logic [1:0] sz,
    logic [31:0] bt, logic [31:0] jt);
    in_t r;
    r = '{st, v, ar, z, wd, wr, ctl, br, jp, sz, bt, jt};
    return r;
  endfunction

  function automatic obs_t mk(
    logic [31:0] ar, logic [31:0] wd, logic [4:0] wr,
    logic [3:0] ctl, logic [1:0] sz, logic tk,
    logic [31:0] tgt, logic [31:0] cnt);
    obs_t r;
    r = '{ar, wd, wr, ctl, sz, tk, tk, tgt, cnt};
    return r;
  endfunction

  function automatic obs_t bub(logic [31:0] cnt);
    return mk(0, 0, 0, 0, 0, 1'b0, RP, cnt);
  endfunction

  task automatic step(in_t i, logic rst, obs_t e,
                      string nm);
    ent_t en;
    Rst                = rst;
    bus.Stall          = i.st;
    bus.ValidIn        = i.v;
    bus.AR             = i.ar;
    bus.Zero           = i.z;
    bus.RtData         = i.wd;
    bus.WriteRegIn     = i.wr;
    bus.RegWriteIn     = i.ctl[3];
    bus.MemReadIn      = i.ctl[2];
    bus.MemWriteIn     = i.ctl[1];
    bus.MemToRegIn     = i.ctl[0];
    bus.BranchIn       = i.br;
    bus.JumpIn         = i.jp;
    bus.MemSizeIn      = i.sz;
    bus.BranchTargetIn = i.bt;
    bus.JumpTargetIn   = i.jt;
    en.cyc = cyc + 1;
    en.e   = e;
    sb.push_back(en);
    nq.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    obs_t  a;
    ent_t  en;
    string nm;
    a = '{bus.AR_M, bus.WriteData_M, bus.WriteReg_M,
          {bus.RegWrite_M, bus.MemRead_M,
           bus.MemWrite_M, bus.MemToReg_M},
          bus.MemSize_M, bus.PCSrc, bus.Flush,
          bus.PCTarget_M, bus.TakenCount};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      en = sb.pop_front();
      nm = nq.pop_front();
      chks++;
      if (a !== en.e) begin
        errs++;
        $display("FAIL %s: got %h want %h", nm, a, en.e);
      end
    end
  end

  initial begin
    in_t idle, jj, hold_add;
    errs = 0;
    chks = 0;
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    jj   = mi(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h240);
    hold_add = mi(1, 1, 9, 0, 0, 5, 4'b1000,
                  0, 0, 0, 0, 0);
    Rst = 1'b0;
    step(idle, 0, bub(0), "rst1");
    step(idle, 0, bub(0), "rst2");
    step(mi(0, 1, 'h40, 0, 'h11, 8, 4'b1101,
            0, 0, 0, 0, 0), 1,
         mk('h40, 'h11, 8, 4'b1101, 0, 0, RP, 0), "lw");
    step(mi(0, 1, 'hAA, 1, 'h22, 0, 0,
            1, 0, 0, 'h100, 'h300), 1,
         mk('hAA, 'h22, 0, 0, 0, 1, 'h100, 0), "beq_t");
    step(mi(0, 1, 'h50, 0, 'h33, 0, 4'b0010,
            0, 0, 2, 0, 0), 1, bub(1), "sq_sw");
    step(mi(0, 1, 'hBB, 0, 'h22, 0, 0,
            1, 0, 0, 'h100, 0), 1,
         mk('hBB, 'h22, 0, 0, 0, 0, RP, 1), "beq_nt");
    step(mi(0, 1, 7, 0, 0, 9, 4'b1000,
            0, 0, 0, 0, 0), 1,
         mk(7, 0, 9, 4'b1000, 0, 0, RP, 1), "add");
    step(mi(0, 1, 'h44, 1, 0, 0, 0,
            1, 1, 0, 'h500, 'h200), 1,
         mk('h44, 0, 0, 0, 0, 1, 'h200, 1), "jmp");
    step(mi(0, 1, 3, 0, 0, 3, 4'b1000,
            0, 0, 0, 0, 0), 1, bub(2), "sq_j");
    step(mi(0, 0, 'h55, 1, 'h66, 4, 4'b1111,
            1, 1, 3, 'h600, 'h700), 1,
         mk('h55, 'h66, 4, 0, 3, 0, RP, 2), "vin0");
    step(mi(0, 1, 'h60, 0, 'h77, 0, 4'b0010,
            0, 0, 3, 0, 0), 1,
         mk('h60, 'h77, 0, 4'b0010, 3, 0, RP, 2), "sz11");
    step(mi(0, 1, 1, 1, 0, 0, 0,
            1, 0, 0, 'h180, 0), 1,
         mk(1, 0, 0, 0, 0, 1, 'h180, 2), "beq_s");
    step(hold_add, 1, bub(3), "stall_bub");
    step(hold_add, 1, bub(3), "stall_h1");
    step(hold_add, 1, bub(3), "stall_h2");
    hold_add.st = 1'b0;
    step(hold_add, 1,
         mk(9, 0, 5, 4'b1000, 0, 0, RP, 3), "unstall");
    step(mi(1, 1, 'h99, 0, 0, 6, 4'b1101,
            0, 0, 0, 0, 0), 1,
         mk(9, 0, 5, 4'b1000, 0, 0, RP, 3), "hold");
    @(negedge Clk);
    #1;
    force dut.cnt_q = 32'hFFFF_FFFE;
    step(idle, 1, bub(32'hFFFF_FFFE), "pre_sat");
    release dut.cnt_q;
    step(jj, 1, mk(0, 0, 0, 0, 0, 1, 'h240,
                   32'hFFFF_FFFE), "j1");
    for (int k = 0; k < 3; k++) begin
      step(jj, 1, bub(32'hFFFF_FFFF), "sat_sq");
      step(jj, 1, mk(0, 0, 0, 0, 0, 1, 'h240,
                     32'hFFFF_FFFF), "sat_j");
    end
    step(idle, 0, bub(0), "rst_mid");
    step(jj, 1, mk(0, 0, 0, 0, 0, 1, 'h240, 0),
         "post_rst_j");
    step(idle, 1, bub(1), "post_rst_sq");
    step(idle, 1, bub(1), "post_rst_idle");
    repeat (3) @(posedge Clk);
    if (sb.size() != 0) begin
      errs++;
      chks++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errs, chks);
    $finish;
  end

endmodule

// File: doc/ex_mem_branch_reg.md
Name: ex_mem_branch_reg

Overview:
EX/MEM pipeline register for the 5-stage pipeline. It captures the execute-stage results (ALU result, Zero flag, store data, destination register, control bits) and resolves branches and jumps in the Memory stage. On a taken branch or jump it drives the PC redirect and a one-cycle flush to the IF/ID and ID/EX registers, and squashes its own next capture. It also keeps a saturating count of taken control transfers.

Parameters:
RESET_PC, 32'h0000_0000, value PCTarget_M drives while reset is asserted and whenever no branch or jump is taken.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  synchronous, active-low reset.
Stall  input  1  hazard-unit hold; register keeps its contents.
ValidIn  input  1  EX holds a real instruction (0 = bubble).
AR  input  32  ALU result from EX.
Zero  input  1  ALU branch-condition flag from EX.
RtData  input  32  store data from EX.
WriteRegIn  input  5  destination register number.
RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, BranchIn, JumpIn  input  1 each  EX control bits.
MemSizeIn  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
BranchTargetIn  input  32  PC+4+(sign-extended imm<<2).
JumpTargetIn  input  32  jump or jr target.
AR_M, WriteData_M  output  32  registered AR and RtData.
WriteReg_M  output  5  registered destination register.
RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M  output  1  registered, gated by valid.
MemSize_M  output  2  registered size.
PCSrc  output  1  take redirect.
PCTarget_M  output  32  redirect address.
Flush  output  1  clear IF/ID and ID/EX this cycle.
TakenCount  output  32  number of taken transfers.

Behaviour:
- Internal state: Valid_M, Zero_M, Branch_M, Jump_M, BrTgt_M, JTgt_M, plus all _M outputs and TakenCount.
- Taken = Valid_M & ((Branch_M & Zero_M) | Jump_M). This is combinational from registered state.
- PCSrc = Taken; Flush = Taken.
- PCTarget_M: if Jump_M, JTgt_M; else if Branch_M, BrTgt_M; else RESET_PC. It is RESET_PC whenever Taken = 0.
- Register update priority on each rising edge:
  1. Rst == 0: all registers cleared to 0, BrTgt_M and JTgt_M set to RESET_PC, TakenCount = 0.
  2. Else if Taken: load a bubble. Valid_M = 0, all control bits 0, data fields 0. This happens even if Stall = 1, so the wrong-path EX instruction is squashed. TakenCount increments.
  3. Else if Stall: hold everything.
  4. Else capture all inputs. Valid_M = ValidIn. If ValidIn = 0, all captured control bits are forced to 0; data fields are still captured.
- Latency: an EX instruction is visible on the _M outputs 1 cycle after its capture edge. The redirect asserts in that same cycle and lasts exactly 1 cycle, because the following edge loads a bubble.
- Because of rule 2, a taken transfer is counted exactly once even when Stall is held.
- TakenCount saturates at 32'hFFFF_FFFF and does not wrap.
- All outputs read 0 in the cycle after reset, except PCTarget_M, which reads RESET_PC.
- Reset asserted mid-redirect: Flush and PCSrc drop in the cycle after the reset edge. The count is not incremented on the reset edge.
- MemSize 11 is passed through unchanged; interpreting it is the memory stage's job.
- No combinational path from any input to any output.

Test Plan:
1. Hold Rst = 0 for 2 edges, then release → all outputs 0, PCTarget_M = RESET_PC, TakenCount = 0.
2. Capture lw: ValidIn = 1, AR = 32'h0000_0040, MemReadIn = 1, MemToRegIn = 1, RegWriteIn = 1, WriteRegIn = 8 → next cycle AR_M = 40h, WriteReg_M = 8, the three control outputs = 1, PCSrc = 0.
3. Capture beq with Zero = 1, BranchTargetIn = 32'h0000_0100, while EX presents an sw (MemWriteIn = 1) → PCSrc = 1, Flush = 1, PCTarget_M = 100h for 1 cycle. The following cycle MemWrite_M = 0, Valid_M = 0, TakenCount = 1.
4. Same beq with Zero = 0 → PCSrc stays 0 and the next instruction is captured normally. Then a jump with JumpTargetIn = 32'h0000_0200 → PCTarget_M = 200h and TakenCount increments.
5. Taken branch held with Stall = 1 for 3 cycles → redirect lasts 1 cycle, bubble loads despite Stall, TakenCount increments by exactly 1, then the register holds the bubble while Stall stays high.
6. Preload TakenCount = FFFF_FFFEh (force), then issue 3 taken jumps → count goes to FFFF_FFFFh and stays there. Separately, assert Rst = 0 during a redirect cycle → cleared on that edge, no increment.
